// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and default parameter values for the CPU run monitor.
// The optional PC trace is enabled by defining CPU_RUN_MONITOR_TRACE_EN.
package cpu_run_monitor_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_e;

    localparam int DEF_PC_W        = 16;
    localparam int DEF_RST_HOLD    = 3;
    localparam int DEF_DRAIN_CYC   = 3;
    localparam int DEF_TIMEOUT_CYC = 25000;
    localparam int DEF_TRACE_DEPTH = 8;

endpackage

// File: rtl/cpu_run_monitor_pc_trace_buf.sv
// Circular PC history buffer. Index 0 on the read port is the most recent
// write; indices at or beyond the valid count read as zero.
module pc_trace_buf #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [PC_W-1:0]          wr_pc_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [PC_W-1:0]          rd_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W:0]   count_q;
    logic [IDX_W-1:0] rd_slot;

    // Write pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + IDX_W'(1);
            if (count_q != DEPTH_CNT) begin
                count_q <= count_q + (IDX_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_pc_i;
        end
    end

    // Read relative to the newest entry, masking slots not yet written.
    always_comb begin
        rd_slot = wr_ptr_q - IDX_W'(1) - rd_idx_i;
        rd_pc_o = '0;
        if ({1'b0, rd_idx_i} < count_q) begin
            rd_pc_o = mem_q[rd_slot];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// CPU run monitor: holds the CPU in reset for a fixed time after start,
// counts running cycles, captures the halt PC, drains the pipeline and
// flags completion or timeout. Define CPU_RUN_MONITOR_TRACE_EN to include
// the PC history buffer; otherwise the trace outputs read as zero.
//
//   state   | meaning
//   IDLE    | waiting for start, CPU held in reset
//   RESET   | CPU reset asserted for RST_HOLD cycles
//   RUN     | CPU running, counting cycles, watching hlt and timeout
//   DRAIN   | halt seen, pipeline drains for DRAIN_CYC cycles
//   DONE    | run ended by halt, CPU left out of reset
//   TIMEOUT | run ended by timeout, CPU forced back into reset
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int RST_HOLD    = DEF_RST_HOLD,
    parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [PC_W-1:0]                pc,
    input  logic                           hlt,
    output logic                           cpu_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic                           timed_out,
    output logic [31:0]                    cycle_count,
    output logic [PC_W-1:0]                halt_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [PC_W-1:0]                trace_rd_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

    localparam int          TMR_W        = 16;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic [31:0]      cycle_count_q;
    logic [PC_W-1:0]  halt_pc_q;
    logic             launch;
    logic             counting;

    // State, phase timer and registered CPU reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Next-state: timers count down to zero; hlt beats timeout in RUN.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_RESET;
                    timer_d = TMR_W'(RST_HOLD - 1);
                end
            end
            S_RESET: begin
                if (timer_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_RUN: begin
                if (hlt) begin
                    state_d = S_DRAIN;
                    timer_d = TMR_W'(DRAIN_CYC - 1);
                end else if (cycle_count_q == TIMEOUT_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; CPU reset is derived from the next state
    // so it releases exactly in the first RUN cycle.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        timed_out   = 1'b0;
        launch      = 1'b0;
        counting    = 1'b0;
        case (state_q)
            S_IDLE:    launch = start;
            S_RESET:   busy = 1'b1;
            S_RUN: begin
                busy     = 1'b1;
                counting = 1'b1;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                counting = 1'b1;
            end
            S_DONE: begin
                done   = 1'b1;
                launch = start;
            end
            S_TIMEOUT: begin
                timed_out = 1'b1;
                launch    = start;
            end
            default: ;
        endcase
        cpu_rst_n_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_DONE);
    end

    // Run statistics: cleared on launch, frozen outside RUN/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_q <= '0;
            halt_pc_q     <= '0;
        end else if (launch) begin
            cycle_count_q <= '0;
            halt_pc_q     <= '0;
        end else begin
            if (counting && (cycle_count_q != 32'hFFFF_FFFF)) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
            if ((state_q == S_RUN) && hlt) begin
                halt_pc_q <= pc;
            end
        end
    end

    assign cpu_rst_n   = cpu_rst_n_q;
    assign cycle_count = cycle_count_q;
    assign halt_pc     = halt_pc_q;

`ifdef CPU_RUN_MONITOR_TRACE_EN
    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (launch),
        .wr_en_i  (counting),
        .wr_pc_i  (pc),
        .rd_idx_i (trace_rd_idx),
        .rd_pc_o  (trace_rd_pc),
        .count_o  (trace_count)
    );
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_rd_idx;
    assign trace_rd_pc      = '0;
    assign trace_count      = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: halt, timeout, halt-on-timeout,
// mid-run abort and PC trace readout. Trace expectations collapse to zero
// when CPU_RUN_MONITOR_TRACE_EN is not defined.
`timescale 1ns/100ps
module tb_cpu_run_monitor;

    localparam int PC_W        = 16;
    localparam int TRACE_DEPTH = 8;
    localparam int IDX_W       = 3;
    localparam int TIMEOUT     = 100;
`ifdef CPU_RUN_MONITOR_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [PC_W-1:0]  pc;
    logic             hlt;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic             timed_out;
    logic [31:0]      cycle_count;
    logic [PC_W-1:0]  halt_pc;
    logic [IDX_W-1:0] trace_rd_idx;
    logic [PC_W-1:0]  trace_rd_pc;
    logic [IDX_W:0]   trace_count;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  exp;
    } trace_vec_t;

    trace_vec_t      vecs[12];
    logic [PC_W-1:0] sb_q[$];
    int              tests_run    = 0;
    int              tests_failed = 0;

    cpu_run_monitor #(
        .PC_W        (PC_W),
        .RST_HOLD    (3),
        .DRAIN_CYC   (3),
        .TIMEOUT_CYC (TIMEOUT),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pc           (pc),
        .hlt          (hlt),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .timed_out    (timed_out),
        .cycle_count  (cycle_count),
        .halt_pc      (halt_pc),
        .trace_rd_idx (trace_rd_idx),
        .trace_rd_pc  (trace_rd_pc),
        .trace_count  (trace_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        logic [PC_W-1:0] want;
        for (int i = lo; i <= hi; i++) begin
            trace_rd_idx = vecs[i].idx;
            sb_q.push_back(vecs[i].exp);
            #1;
            want = sb_q.pop_front();
            check($sformatf("trace_vec%0d", i), 32'(trace_rd_pc), 32'(want));
        end
    endtask

    // Pulse start and walk through the reset phase; returns in RUN cycle 1.
    task automatic launch(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"},        32'(busy), 32'd1);
        check({tag, "_cpurst0"},     32'(cpu_rst_n), 32'd0);
        check({tag, "_clr_count"},   cycle_count, 32'd0);
        check({tag, "_clr_hpc"},     32'(halt_pc), 32'd0);
        check({tag, "_clr_done"},    32'(done), 32'd0);
        check({tag, "_clr_tmo"},     32'(timed_out), 32'd0);
        check({tag, "_clr_tcount"},  32'(trace_count), 32'd0);
        step();
        step();
        check({tag, "_rst_hold"},    32'(cpu_rst_n), 32'd0);
        step();
        check({tag, "_run_entry"},   32'(cpu_rst_n), 32'd1);
        check({tag, "_run_count0"},  cycle_count, 32'd0);
    endtask

    // Assert hlt in RUN cycle k with pc=hpc, keep hlt high through drain.
    task automatic run_halt(input string tag, input int k, input logic [PC_W-1:0] hpc);
        repeat (k - 1) step();
        check({tag, "_pre_count"}, cycle_count, 32'(k - 1));
        hlt = 1'b1;
        pc  = hpc;
        step();
        pc  = 16'h0099;
        check({tag, "_halt_pc"},   32'(halt_pc), 32'(hpc));
        check({tag, "_drain_cnt"}, cycle_count, 32'(k));
        check({tag, "_drain_bsy"}, 32'(busy), 32'd1);
        step();
        step();
        check({tag, "_drain_end_done"}, 32'(done), 32'd0);
        check({tag, "_drain_end_cnt"},  cycle_count, 32'(k + 2));
        step();
        check({tag, "_done"},      32'(done), 32'd1);
        check({tag, "_done_bsy"},  32'(busy), 32'd0);
        check({tag, "_done_tmo"},  32'(timed_out), 32'd0);
        check({tag, "_done_cnt"},  cycle_count, 32'(k + 3));
        check({tag, "_done_crst"}, 32'(cpu_rst_n), 32'd1);
        check({tag, "_done_hpc"},  32'(halt_pc), 32'(hpc));
        trace_rd_idx = '0;
        #1;
        check({tag, "_tcount"},    32'(trace_count), TRACE_ON ? 32'd8 : 32'd0);
        check({tag, "_tidx0"},     32'(trace_rd_pc), TRACE_ON ? 32'h0099 : 32'd0);
        hlt = 1'b0;
        repeat (3) step();
        check({tag, "_hold_cnt"},  cycle_count, 32'(k + 3));
        check({tag, "_hold_done"}, 32'(done), 32'd1);
        check({tag, "_hold_hpc"},  32'(halt_pc), 32'(hpc));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        pc           = '0;
        hlt          = 1'b0;
        trace_rd_idx = '0;

        // Partial fill (3 writes: 0,2,4), then full fill of 12 writes 0..0x16.
        vecs[0] = '{idx: 3'd0, exp: TRACE_ON ? 16'h0004 : 16'h0000};
        vecs[1] = '{idx: 3'd2, exp: TRACE_ON ? 16'h0000 : 16'h0000};
        vecs[2] = '{idx: 3'd3, exp: 16'h0000};
        vecs[3] = '{idx: 3'd7, exp: 16'h0000};
        for (int i = 0; i < 8; i++) begin
            vecs[4 + i].idx = IDX_W'(i);
            vecs[4 + i].exp = TRACE_ON ? PC_W'(16'h0016 - 2 * i) : '0;
        end

        #3;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_crst",   32'(cpu_rst_n), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_tmo",    32'(timed_out), 32'd0);
        check("rst_count",  cycle_count, 32'd0);
        check("rst_hpc",    32'(halt_pc), 32'd0);
        check("rst_tcount", 32'(trace_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Normal halted run.
        launch("halt");
        run_halt("halt", 10, 16'h0014);

        // Trace fill with start pulsed mid-run (must be ignored).
        launch("trace");
        for (int i = 0; i < 12; i++) begin
            pc    = PC_W'(2 * i);
            hlt   = (i == 8);
            start = (i == 5);
            if (i == 3) begin
                check("trace_part_count", 32'(trace_count), TRACE_ON ? 32'd3 : 32'd0);
                apply_vecs(0, 3);
            end
            step();
        end
        hlt   = 1'b0;
        start = 1'b0;
        check("trace_done",   32'(done), 32'd1);
        check("trace_cnt",    cycle_count, 32'd12);
        check("trace_hpc",    32'(halt_pc), 32'h0010);
        check("trace_tcount", 32'(trace_count), TRACE_ON ? 32'd8 : 32'd0);
        apply_vecs(4, 11);

        // Timeout with hlt never asserted.
        launch("tmo");
        repeat (TIMEOUT - 1) step();
        check("tmo_pre_cnt",  cycle_count, 32'(TIMEOUT - 1));
        check("tmo_pre_flag", 32'(timed_out), 32'd0);
        step();
        check("tmo_flag",  32'(timed_out), 32'd1);
        check("tmo_cnt",   cycle_count, 32'(TIMEOUT));
        check("tmo_crst",  32'(cpu_rst_n), 32'd0);
        check("tmo_done",  32'(done), 32'd0);
        check("tmo_busy",  32'(busy), 32'd0);
        repeat (3) step();
        check("tmo_hold_cnt", cycle_count, 32'(TIMEOUT));

        // hlt in the exact timeout cycle: halt wins.
        launch("tie");
        repeat (TIMEOUT - 1) step();
        hlt = 1'b1;
        pc  = 16'h0ABC;
        step();
        hlt = 1'b0;
        check("tie_tmo",  32'(timed_out), 32'd0);
        check("tie_busy", 32'(busy), 32'd1);
        check("tie_hpc",  32'(halt_pc), 32'h0ABC);
        repeat (3) step();
        check("tie_done",  32'(done), 32'd1);
        check("tie_tmo2",  32'(timed_out), 32'd0);
        check("tie_cnt",   cycle_count, 32'(TIMEOUT + 3));

        // Abort at RUN cycle 50, then a normal run.
        launch("abort");
        repeat (49) step();
        check("abort_pre_cnt", cycle_count, 32'd49);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_crst",   32'(cpu_rst_n), 32'd0);
        check("abort_count",  cycle_count, 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_tmo",    32'(timed_out), 32'd0);
        check("abort_hpc",    32'(halt_pc), 32'd0);
        check("abort_tcount", 32'(trace_count), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_idle_busy",  32'(busy), 32'd0);
        check("abort_idle_count", cycle_count, 32'd0);
        check("abort_idle_crst",  32'(cpu_rst_n), 32'd0);
        launch("rerun");
        run_halt("rerun", 10, 16'h0014);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter PC_W, default 16, width of the monitored PC.
REQ-002 Parameter RST_HOLD, default 3, cycles cpu_rst_n is held low after start.
REQ-003 Parameter DRAIN_CYC, default 3, cycles allowed for pipeline drain after hlt.
REQ-004 Parameter TIMEOUT_CYC, default 25000, RUN-cycle limit before timeout.
REQ-005 Parameter TRACE_DEPTH, default 8, PC history entries; power of 2, at least 2.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle pulse that launches a run.
REQ-009 pc  in  PC_W  CPU program counter.
REQ-010 hlt  in  1  CPU halt indication.
REQ-011 cpu_rst_n  out  1  registered active-low reset to the CPU.
REQ-012 busy  out  1  high in RESET, RUN or DRAIN.
REQ-013 done  out  1  sticky; run ended by halt.
REQ-014 timed_out  out  1  sticky; run ended by timeout.
REQ-015 cycle_count  out  32  CPU-running cycles of the current/last run.
REQ-016 halt_pc  out  PC_W  pc sampled in the cycle hlt was first seen.
REQ-017 trace_rd_idx  in  $clog2(TRACE_DEPTH)  history index; 0 = most recent.
REQ-018 trace_rd_pc  out  PC_W  combinational trace entry at trace_rd_idx.
REQ-019 trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturating at TRACE_DEPTH.

Function
REQ-020 States: IDLE, RESET, RUN, DRAIN, DONE, TIMEOUT; one-hot or binary at implementer's choice.
REQ-021 IDLE/DONE/TIMEOUT + start -> RESET; clears cycle_count, halt_pc, done, timed_out and the trace in that edge.
REQ-022 start in RESET, RUN or DRAIN is ignored.
REQ-023 RESET drives cpu_rst_n=0 for exactly RST_HOLD cycles, then enters RUN with cpu_rst_n=1 in the first RUN cycle.
REQ-024 In RUN and DRAIN, cycle_count increments by 1 per cycle, saturating at 2^32-1.
REQ-025 In RUN and DRAIN, pc is written to the trace every cycle; write pointer wraps modulo TRACE_DEPTH, oldest entry overwritten.
REQ-026 RUN + hlt=1 -> DRAIN; halt_pc loaded with pc in that cycle.
REQ-027 RUN with cycle_count == TIMEOUT_CYC-1 and hlt=0 -> TIMEOUT; hlt=1 in the same cycle wins (DRAIN).
REQ-028 DRAIN lasts exactly DRAIN_CYC cycles regardless of hlt, then DONE with done=1.
REQ-029 DONE holds cpu_rst_n=1; TIMEOUT drives cpu_rst_n=0; both hold counters, halt_pc and trace stable.
REQ-030 trace_rd_pc returns 0 when trace_rd_idx >= trace_count.
REQ-031 done and timed_out are never both 1.

Reset
REQ-032 rst_n low asynchronously forces IDLE, cpu_rst_n=0, busy=0, done=0, timed_out=0, cycle_count=0, halt_pc=0, trace_count=0.
REQ-033 rst_n low mid-run aborts it; no flag is set; release returns to IDLE awaiting start.

Configuration
REQ-034 Macro CPU_RUN_MONITOR_TRACE_EN defined: trace storage and read port implemented per REQ-025/030.
REQ-035 Macro undefined: no trace storage; trace_rd_pc and trace_count tied to 0; all other behaviour unchanged.

Structure
REQ-036 Package cpu_run_monitor_pkg holds the state enum type and the default parameter constants.
REQ-037 Trace buffer is sub-module pc_trace_buf (write enable, clear, read index, count), instantiated only under CPU_RUN_MONITOR_TRACE_EN.

Verification
REQ-038 Reset then start, hlt at RUN cycle 10 with pc=0x0014 -> halt_pc=0x0014, done=1 after 3 drain cycles, cycle_count=13.
REQ-039 start then hlt never asserted, TIMEOUT_CYC=100 -> timed_out=1 at cycle_count=100, cpu_rst_n=0, done=0.
REQ-040 pc = 0x0000,0x0002,... for 12 RUN cycles, TRACE_DEPTH=8 -> trace_count=8, idx0=0x0016, idx7=0x0008, idx beyond count reads 0.
REQ-041 hlt=1 in the exact timeout cycle -> DRAIN entered, done=1, timed_out=0.
REQ-042 rst_n pulsed low during RUN at cycle 50 -> immediate IDLE, all outputs reset values, second start runs normally.
REQ-043 Build without CPU_RUN_MONITOR_TRACE_EN, repeat REQ-038 -> identical flags/counts, trace_count=0, trace_rd_pc=0.
